// File: rtl/mul_n.sv
// mul_n: sequential unsigned shift-and-add multiplier with start/ready handshake
//   clk_i       system clock, all state on rising edge
//   reset_ni    synchronous active-low reset
//   start_i     request, sampled only while idle
//   a_i, b_i    unsigned multiplicand / multiplier, latched on the start edge
//   prod_lo_o   low half of the product (registered)
//   prod_hi_o   high half of the product (registered)
//   ovf_o       product does not fit in bits (prod_hi_o != 0)
//   ready_o     one-cycle completion strobe
//   busy_o      operation in progress
module mul_n #(
    parameter int bits = 8
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            start_i,
    input  logic [bits-1:0] a_i,
    input  logic [bits-1:0] b_i,
    output logic [bits-1:0] prod_lo_o,
    output logic [bits-1:0] prod_hi_o,
    output logic            ovf_o,
    output logic            ready_o,
    output logic            busy_o
);
    localparam int CW = $clog2(bits);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t              state_q;
    logic [2*bits-1:0]   mcand_q;
    logic [2*bits-1:0]   acc_q;
    logic [bits-1:0]     mplier_q;
    logic [CW-1:0]       cnt_q;
    assign busy_o = (state_q != IDLE);
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            prod_lo_o <= '0;
            prod_hi_o <= '0;
            ovf_o     <= 1'b0;
            ready_o   <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            case (state_q)
                IDLE: if (start_i) begin
                    mcand_q  <= {{bits{1'b0}}, a_i};
                    mplier_q <= b_i;
                    acc_q    <= '0;
                    cnt_q    <= '0;
                    state_q  <= RUN;
                end
                RUN: begin
                    // always exactly bits iterations, even for zero operands
                    if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CW'(bits - 1)) state_q <= DONE;
                end
                DONE: begin
                    prod_lo_o <= acc_q[bits-1:0];
                    prod_hi_o <= acc_q[2*bits-1:bits];
                    ovf_o     <= |acc_q[2*bits-1:bits];
                    ready_o   <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mul_n.md
# mul_n

Sequential unsigned shift-and-add multiplier, the multiplicative counterpart of the calculator's repeated-subtraction divider. On a `start` pulse it latches both operands, forms the full `2*bits` product over exactly `bits` iteration cycles, and then loads registered result outputs with a one-cycle `ready` strobe. It sits beside the divider in the calculator datapath and uses the same start/ready handshake, so the control FSM can drive either unit identically.

## Interface
- `bits`, default 8: operand width; legal range 2..16.

- `clk`  in  1  single system clock, all state on rising edge
- `reset`  in  1  synchronous, active-low reset (sampled on `clk` rising edge; low = reset)
- `start`  in  1  request; sampled only in IDLE
- `a`  in  `bits`  multiplicand, unsigned; may change at any time
- `b`  in  `bits`  multiplier, unsigned; may change at any time
- `prod_lo`  out  `bits`  low half of product (registered)
- `prod_hi`  out  `bits`  high half of product (registered)
- `ovf`  out  1  product does not fit in `bits` (`prod_hi != 0`), registered with the result
- `ready`  out  1  one-cycle completion strobe, registered
- `busy`  out  1  high while an operation is in progress (RUN or DONE)

## Operation
- Internal regs: `mcand` (2*`bits`), `mplier` (`bits`), `acc` (2*`bits`), `cnt` (wide enough for `bits`), `state`.
- States: IDLE, RUN, DONE.
- IDLE: if `start`=1 at a clock edge: `mcand` <= zero-extended `a`, `mplier` <= `b`, `acc` <= 0, `cnt` <= 0, go RUN. Otherwise hold.
- RUN, every edge: if `mplier[0]` then `acc` <= `acc` + `mcand` (mod 2^(2*bits), cannot actually wrap); `mcand` <= `mcand` << 1; `mplier` <= `mplier` >> 1; `cnt` <= `cnt`+1; when `cnt` = `bits`-1 on this edge, go DONE.
- No early termination: zero operands still take the full `bits` iterations.
- DONE, one edge: `prod_lo` <= `acc[bits-1:0]`, `prod_hi` <= `acc[2*bits-1:bits]`, `ovf` <= |`acc[2*bits-1:bits]`, `ready` <= 1, go IDLE.
- `ready` <= 0 on every edge not leaving DONE.
- `start` is ignored in RUN and DONE; `a`/`b` changes after the start edge have no effect on the running operation.
- Result outputs hold their value until the next DONE or reset.
- `busy` = (state != IDLE), combinational from state.

## Timing
- Reset (`reset`=0 at an edge): state IDLE; `mcand`, `mplier`, `acc`, `cnt` = 0; `prod_lo`=0, `prod_hi`=0, `ovf`=0, `ready`=0; `busy`=0 after the edge. Reset dominates `start` and aborts any operation in progress, without a `ready` strobe.
- Edge E0 samples `start`=1 in IDLE; edges E1..E`bits` are the iterations; edge E(`bits`+1) is DONE: outputs and `ready`=1 become visible after E(`bits`+1); `ready` falls after E(`bits`+2).
- Latency start edge -> `ready` visible: `bits`+1 cycles (9 for `bits`=8).
- `start` held high continuously: a new operation is sampled at E(`bits`+2), so back-to-back period is `bits`+2 cycles; operands are those present at that edge.
- `busy` high from after E0 until after E(`bits`+1).
- Reset released mid-stream: first `start` honoured at the first edge with `reset`=1.

## Test plan
- `bits`=8, reset low 2 cycles -> all outputs 0, `busy`=0; release; a=13, b=11, start 1 cycle -> `ready` exactly 9 cycles after start edge, one cycle wide, `prod_lo`=143, `prod_hi`=0, `ovf`=0.
- a=255, b=255 -> `prod_lo`=0x01, `prod_hi`=0xFE, `ovf`=1; outputs hold after `ready` drops until next completion.
- a=0, b=200 -> still 9-cycle latency, product 0, `ovf`=0; then a=200, b=1 -> `prod_lo`=200, `ovf`=0.
- a=16, b=16 start; change a=3, b=3 and pulse `start` during RUN -> result 256 (`prod_lo`=0, `prod_hi`=1, `ovf`=1), no second operation launched, `busy` stays high exactly 9 cycles.
- `start` held high with a=7, b=6 -> `ready` strobes every 10 cycles, each with product 42.
- Reset asserted 4 cycles into an operation -> no `ready`, outputs 0, IDLE; next start a=12, b=12 -> 144 after 9 cycles. Plus 1000 random operand pairs vs. a behavioural a*b model, for `bits`=8 and `bits`=4.
